// File: rtl/cart_sdram_arbiter_if.sv
// SDRAM-side request/acknowledge bus between cart_sdram_arbiter (master) and the SDRAM controller (slave).
interface cart_sdram_arbiter_if #(
   parameter int AW = 25
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic [7:0]    mem_dout;
   logic          mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_din, input mem_dout, mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr, mem_din, output mem_dout, mem_ack);
endinterface

// File: rtl/cart_sdram_arbiter.sv
// cart_sdram_arbiter: shares one SDRAM port between the ROM loader write stream and cartridge reads.
// Defining CART_PREFETCH_EN adds a second cache line filled by a speculative read of the next address.
module cart_sdram_arbiter #(
   parameter int AW      = 25,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 ld_wr,
   input  logic [AW-1:0]        ld_addr,
   input  logic [7:0]           ld_data,
   output logic                 ld_busy,
   input  logic                 cart_rd,
   input  logic [19:0]          cart_addr,
   output logic [7:0]           cart_data,
   output logic                 cart_valid,
   output logic                 err_to,
   cart_sdram_arbiter_if.master mem
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, ABORT = 2'd3} state_t;

   state_t        state_r;
   logic          mem_req_r, mem_we_r;
   logic [AW-1:0] mem_addr_r;
   logic [7:0]    mem_din_r;
   logic [TW-1:0] to_cnt_r;
   logic          hold_valid_r;
   logic [AW-1:0] hold_addr_r;
   logic [7:0]    hold_data_r;
   logic          cache_valid_r;
   logic [19:0]   cache_addr_r;
   logic [7:0]    cache_data_r;
   logic          cart_rd_q_r, req_pend_r, pf_fetch_r;
   logic [19:0]   cart_addr_q_r;
   logic [7:0]    cart_data_r;
   logic          cart_valid_r, err_to_r;
`ifdef CART_PREFETCH_EN
   logic          pf_valid_r, pf_want_r;
   logic [19:0]   pf_addr_r;
   logic [7:0]    pf_data_r;
   logic          inval_pf_s;
`endif

   logic          new_req_s, req_s, ld_acc_s, moved_s, wr_evt_s, inval_main_s, hit_s, pf_go_s;
   logic [AW-1:0] wr_addr_s;
   logic [7:0]    hit_data_s;

   function automatic logic [AW-1:0] widen(input logic [19:0] a);
      widen = {{(AW-20){1'b0}}, a};
   endfunction

   // Request edge detection, hit lookup and write-driven cache invalidation.
   always_comb begin
      new_req_s    = cart_rd && (!cart_rd_q_r || (cart_addr != cart_addr_q_r));
      req_s        = cart_rd && (new_req_s || req_pend_r);
      ld_acc_s     = ld_wr && !hold_valid_r;
      moved_s      = (cart_addr != mem_addr_r[19:0]);
      wr_addr_s    = (state_r == WRITE) ? mem_addr_r : ld_addr;
      // Invalidate both when a write is accepted and when it lands, so an in-flight read cannot leave stale data.
      wr_evt_s     = ld_acc_s || ((state_r == WRITE) && mem.mem_ack);
      inval_main_s = wr_evt_s && ((wr_addr_s == widen(cache_addr_r)) || (wr_addr_s == {AW{1'b0}}));
`ifdef CART_PREFETCH_EN
      inval_pf_s   = wr_evt_s && ((wr_addr_s == widen(pf_addr_r)) || (wr_addr_s == {AW{1'b0}}));
      hit_s        = (cache_valid_r && (cart_addr == cache_addr_r)) || (pf_valid_r && (cart_addr == pf_addr_r));
      hit_data_s   = (cache_valid_r && (cart_addr == cache_addr_r)) ? cache_data_r : pf_data_r;
      pf_go_s      = pf_want_r && cache_valid_r;
`else
      hit_s        = cache_valid_r && (cart_addr == cache_addr_r);
      hit_data_s   = cache_data_r;
      pf_go_s      = 1'b0;
`endif
   end

   // Arbitration FSM, loader holding register, cache line(s) and all registered outputs.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r       <= IDLE;
         mem_req_r     <= 1'b0;
         mem_we_r      <= 1'b0;
         mem_addr_r    <= {AW{1'b0}};
         mem_din_r     <= 8'h00;
         to_cnt_r      <= {TW{1'b0}};
         hold_valid_r  <= 1'b0;
         hold_addr_r   <= {AW{1'b0}};
         hold_data_r   <= 8'h00;
         cache_valid_r <= 1'b0;
         cache_addr_r  <= 20'h00000;
         cache_data_r  <= 8'h00;
         cart_rd_q_r   <= 1'b0;
         cart_addr_q_r <= 20'h00000;
         req_pend_r    <= 1'b0;
         pf_fetch_r    <= 1'b0;
         cart_data_r   <= 8'h00;
         cart_valid_r  <= 1'b0;
         err_to_r      <= 1'b0;
`ifdef CART_PREFETCH_EN
         pf_valid_r    <= 1'b0;
         pf_want_r     <= 1'b0;
         pf_addr_r     <= 20'h00000;
         pf_data_r     <= 8'h00;
`endif
      end else begin
         cart_rd_q_r   <= cart_rd;
         cart_addr_q_r <= cart_addr;
         cart_valid_r  <= 1'b0;
         if (new_req_s) begin
            req_pend_r <= 1'b1;
         end
         if (ld_acc_s) begin
            hold_valid_r <= 1'b1;
            hold_addr_r  <= ld_addr;
            hold_data_r  <= ld_data;
         end
         if (inval_main_s) begin
            cache_valid_r <= 1'b0;
         end
`ifdef CART_PREFETCH_EN
         if (inval_pf_s) begin
            pf_valid_r <= 1'b0;
         end
`endif
         case (state_r)
            IDLE: begin
               if (ld_acc_s || hold_valid_r) begin
                  state_r    <= WRITE;
                  mem_req_r  <= 1'b1;
                  mem_we_r   <= 1'b1;
                  mem_addr_r <= hold_valid_r ? hold_addr_r : ld_addr;
                  mem_din_r  <= hold_valid_r ? hold_data_r : ld_data;
                  to_cnt_r   <= TW'(1);
               end else if (req_s && hit_s) begin
                  cart_data_r  <= hit_data_s;
                  cart_valid_r <= 1'b1;
                  req_pend_r   <= 1'b0;
               end else if (req_s) begin
                  state_r    <= READ;
                  mem_req_r  <= 1'b1;
                  mem_we_r   <= 1'b0;
                  mem_addr_r <= widen(cart_addr);
                  to_cnt_r   <= TW'(1);
                  req_pend_r <= 1'b0;
                  pf_fetch_r <= 1'b0;
               end else if (pf_go_s) begin
                  state_r    <= READ;
                  mem_req_r  <= 1'b1;
                  mem_we_r   <= 1'b0;
                  mem_addr_r <= widen(cache_addr_r + 20'd1);
                  to_cnt_r   <= TW'(1);
                  pf_fetch_r <= 1'b1;
`ifdef CART_PREFETCH_EN
                  pf_want_r  <= 1'b0;
`endif
               end else begin
                  req_pend_r <= 1'b0;
               end
            end
            WRITE: begin
               if (mem.mem_ack) begin
                  state_r      <= IDLE;
                  mem_req_r    <= 1'b0;
                  mem_we_r     <= 1'b0;
                  hold_valid_r <= 1'b0;
               end else if (to_cnt_r == TW'(TIMEOUT)) begin
                  state_r      <= ABORT;
                  mem_req_r    <= 1'b0;
                  mem_we_r     <= 1'b0;
                  hold_valid_r <= 1'b0;
                  err_to_r     <= 1'b1;
               end else begin
                  to_cnt_r <= to_cnt_r + 1'b1;
               end
            end
            READ: begin
               if (mem.mem_ack) begin
                  state_r   <= IDLE;
                  mem_req_r <= 1'b0;
                  if (pf_fetch_r) begin
`ifdef CART_PREFETCH_EN
                     pf_valid_r <= 1'b1;
                     pf_addr_r  <= mem_addr_r[19:0];
                     pf_data_r  <= mem.mem_dout;
`endif
                  end else begin
                     cache_valid_r <= 1'b1;
                     cache_addr_r  <= mem_addr_r[19:0];
                     cache_data_r  <= mem.mem_dout;
                     cart_data_r   <= mem.mem_dout;
                     // A read whose address moved away still fills the cache but is not reported.
                     cart_valid_r  <= !moved_s;
`ifdef CART_PREFETCH_EN
                     pf_want_r     <= 1'b1;
`endif
                  end
               end else if (to_cnt_r == TW'(TIMEOUT)) begin
                  state_r   <= ABORT;
                  mem_req_r <= 1'b0;
                  err_to_r  <= 1'b1;
                  if (!pf_fetch_r) begin
                     cart_data_r   <= 8'hFF;
                     cart_valid_r  <= !moved_s;
                     cache_valid_r <= 1'b0;
                  end else begin
                     cart_valid_r  <= 1'b0;
                  end
               end else begin
                  to_cnt_r <= to_cnt_r + 1'b1;
               end
            end
            ABORT: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ld_busy      = hold_valid_r;
   assign cart_data    = cart_data_r;
   assign cart_valid   = cart_valid_r;
   assign err_to       = err_to_r;
   assign mem.mem_req  = mem_req_r;
   assign mem.mem_we   = mem_we_r;
   assign mem.mem_addr = mem_addr_r;
   assign mem.mem_din  = mem_din_r;
endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Directed self-checking bench for cart_sdram_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_cart_sdram_arbiter;
   logic        clk;
   logic        reset;
   logic        ld_wr;
   logic [24:0] ld_addr;
   logic [7:0]  ld_data;
   logic        ld_busy;
   logic        cart_rd;
   logic [19:0] cart_addr;
   logic [7:0]  cart_data;
   logic        cart_valid;
   logic        err_to;
   int          nvec;
   int          nerr;
   int          n_req;
   logic        req_q;

   cart_sdram_arbiter_if #(.AW(25)) mem_bus ();

   cart_sdram_arbiter #(.AW(25), .TIMEOUT(64)) dut (
      .clk_sys    (clk),
      .reset      (reset),
      .ld_wr      (ld_wr),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_busy    (ld_busy),
      .cart_rd    (cart_rd),
      .cart_addr  (cart_addr),
      .cart_data  (cart_data),
      .cart_valid (cart_valid),
      .err_to     (err_to),
      .mem        (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts SDRAM request starts (rising edges of mem_req).
   always @(posedge clk) begin
      req_q <= mem_bus.mem_req;
      if (mem_bus.mem_req && !req_q) n_req <= n_req + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
      $fatal(1);
   end

   // Waits (bounded) for mem_req, acks it in its lat-th cycle, returns on the falling edge after the ack.
   task automatic serve(input int lat, input logic [7:0] rdata);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (mem_bus.mem_req) seen = 1'b1;
         else @(negedge clk);
      end
      if (seen) begin
         repeat (lat - 1) @(negedge clk);
         mem_bus.mem_ack  = 1'b1;
         mem_bus.mem_dout = rdata;
         @(negedge clk);
         mem_bus.mem_ack  = 1'b0;
         mem_bus.mem_dout = 8'h00;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      nvec++; if (mem_bus.mem_req !== 1'b0) begin nerr++; $display("FAIL rst_mem_req: got %b want 0", mem_bus.mem_req); end
      nvec++; if (mem_bus.mem_we !== 1'b0) begin nerr++; $display("FAIL rst_mem_we: got %b want 0", mem_bus.mem_we); end
      nvec++; if (mem_bus.mem_addr !== 25'h0) begin nerr++; $display("FAIL rst_mem_addr: got %h want 0", mem_bus.mem_addr); end
      nvec++; if (mem_bus.mem_din !== 8'h00) begin nerr++; $display("FAIL rst_mem_din: got %h want 00", mem_bus.mem_din); end
      nvec++; if (ld_busy !== 1'b0) begin nerr++; $display("FAIL rst_ld_busy: got %b want 0", ld_busy); end
      nvec++; if (cart_data !== 8'h00) begin nerr++; $display("FAIL rst_cart_data: got %h want 00", cart_data); end
      nvec++; if (cart_valid !== 1'b0) begin nerr++; $display("FAIL rst_cart_valid: got %b want 0", cart_valid); end
      nvec++; if (err_to !== 1'b0) begin nerr++; $display("FAIL rst_err_to: got %b want 0", err_to); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_loader_write;
      int r0;
      r0 = n_req;
      ld_wr = 1'b1; ld_addr = 25'h0012345; ld_data = 8'hA5;
      @(negedge clk);
      ld_wr = 1'b0;
      nvec++; if ({mem_bus.mem_req, mem_bus.mem_we} !== 2'b11) begin nerr++; $display("FAIL wr_req_we: got %b want 11", {mem_bus.mem_req, mem_bus.mem_we}); end
      nvec++; if (mem_bus.mem_addr !== 25'h0012345) begin nerr++; $display("FAIL wr_addr: got %h want 0012345", mem_bus.mem_addr); end
      nvec++; if (mem_bus.mem_din !== 8'hA5) begin nerr++; $display("FAIL wr_din: got %h want a5", mem_bus.mem_din); end
      nvec++; if (ld_busy !== 1'b1) begin nerr++; $display("FAIL wr_busy1: got %b want 1", ld_busy); end
      @(negedge clk);
      nvec++; if ({mem_bus.mem_req, ld_busy} !== 2'b11) begin nerr++; $display("FAIL wr_cycle2: got req,busy=%b want 11", {mem_bus.mem_req, ld_busy}); end
      @(negedge clk);
      nvec++; if ({mem_bus.mem_req, mem_bus.mem_we, ld_busy} !== 3'b111) begin nerr++; $display("FAIL wr_cycle3: got %b want 111", {mem_bus.mem_req, mem_bus.mem_we, ld_busy}); end
      mem_bus.mem_ack = 1'b1;
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      nvec++; if ({mem_bus.mem_req, ld_busy} !== 2'b00) begin nerr++; $display("FAIL wr_after_ack: got req,busy=%b want 00", {mem_bus.mem_req, ld_busy}); end
      repeat (3) @(negedge clk);
      nvec++; if (n_req - r0 !== 1) begin nerr++; $display("FAIL wr_count: got %0d requests want 1", n_req - r0); end
   endtask

   task automatic test_cart_miss_hit;
      int r0;
      r0 = n_req;
      cart_rd = 1'b1; cart_addr = 20'h00100;
      @(negedge clk);
      nvec++; if ({mem_bus.mem_req, mem_bus.mem_we} !== 2'b10) begin nerr++; $display("FAIL miss_req: got req,we=%b want 10", {mem_bus.mem_req, mem_bus.mem_we}); end
      nvec++; if (mem_bus.mem_addr !== 25'h0000100) begin nerr++; $display("FAIL miss_addr: got %h want 0000100", mem_bus.mem_addr); end
      serve(2, 8'h3C);
      nvec++; if ({cart_valid, cart_data} !== {1'b1, 8'h3C}) begin nerr++; $display("FAIL miss_data: got valid=%b data=%h want 1/3c", cart_valid, cart_data); end
      @(negedge clk);
      nvec++; if (cart_valid !== 1'b0) begin nerr++; $display("FAIL miss_pulse: got %b want 0", cart_valid); end
      cart_rd = 1'b0;
      @(negedge clk);
      cart_rd = 1'b1;
      @(negedge clk);
      nvec++; if ({cart_valid, cart_data, mem_bus.mem_req} !== {1'b1, 8'h3C, 1'b0}) begin nerr++; $display("FAIL hit: got valid=%b data=%h req=%b want 1/3c/0", cart_valid, cart_data, mem_bus.mem_req); end
      @(negedge clk);
      nvec++; if (cart_valid !== 1'b0) begin nerr++; $display("FAIL hit_pulse: got %b want 0", cart_valid); end
      nvec++; if (n_req - r0 !== 1) begin nerr++; $display("FAIL hit_count: got %0d requests want 1", n_req - r0); end
      cart_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_and_read_same_cycle;
      ld_wr = 1'b1; ld_addr = 25'h0000200; ld_data = 8'h5A;
      cart_rd = 1'b1; cart_addr = 20'h00300;
      @(negedge clk);
      ld_wr = 1'b0;
      nvec++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr} !== {2'b11, 25'h0000200}) begin nerr++; $display("FAIL sim_write_first: got req,we=%b addr=%h want 11/0000200", {mem_bus.mem_req, mem_bus.mem_we}, mem_bus.mem_addr); end
      serve(2, 8'h00);
      nvec++; if ({mem_bus.mem_req, cart_valid} !== 2'b00) begin nerr++; $display("FAIL sim_gap: got req,valid=%b want 00", {mem_bus.mem_req, cart_valid}); end
      @(negedge clk);
      nvec++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr} !== {2'b10, 25'h0000300}) begin nerr++; $display("FAIL sim_read_next: got req,we=%b addr=%h want 10/0000300", {mem_bus.mem_req, mem_bus.mem_we}, mem_bus.mem_addr); end
      serve(1, 8'hC3);
      nvec++; if ({cart_valid, cart_data} !== {1'b1, 8'hC3}) begin nerr++; $display("FAIL sim_data: got valid=%b data=%h want 1/c3", cart_valid, cart_data); end
      cart_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_invalidate;
      cart_rd = 1'b1; cart_addr = 20'h00100;
      @(negedge clk);
      nvec++; if (mem_bus.mem_req !== 1'b1) begin nerr++; $display("FAIL inv_refill_req: got %b want 1", mem_bus.mem_req); end
      serve(1, 8'h3C);
      nvec++; if (cart_data !== 8'h3C) begin nerr++; $display("FAIL inv_refill_data: got %h want 3c", cart_data); end
      cart_rd = 1'b0;
      @(negedge clk);
      ld_wr = 1'b1; ld_addr = 25'h0000100; ld_data = 8'h77;
      @(negedge clk);
      ld_wr = 1'b0;
      serve(1, 8'h00);
      nvec++; if (ld_busy !== 1'b0) begin nerr++; $display("FAIL inv_busy: got %b want 0", ld_busy); end
      cart_rd = 1'b1;
      @(negedge clk);
      nvec++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr} !== {2'b10, 25'h0000100}) begin nerr++; $display("FAIL inv_miss: got req,we=%b addr=%h want 10/0000100", {mem_bus.mem_req, mem_bus.mem_we}, mem_bus.mem_addr); end
      serve(1, 8'h77);
      nvec++; if ({cart_valid, cart_data} !== {1'b1, 8'h77}) begin nerr++; $display("FAIL inv_data: got valid=%b data=%h want 1/77", cart_valid, cart_data); end
      cart_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_protocol_violation;
      int r0;
      r0 = n_req;
      ld_wr = 1'b1; ld_addr = 25'h0000500; ld_data = 8'h11;
      @(negedge clk);
      ld_addr = 25'h0000600; ld_data = 8'h22;
      @(negedge clk);
      ld_wr = 1'b0;
      nvec++; if ({mem_bus.mem_addr, mem_bus.mem_din} !== {25'h0000500, 8'h11}) begin nerr++; $display("FAIL viol_kept: got addr=%h din=%h want 0000500/11", mem_bus.mem_addr, mem_bus.mem_din); end
      serve(1, 8'h00);
      repeat (3) @(negedge clk);
      nvec++; if ({n_req - r0, ld_busy} !== {32'd1, 1'b0}) begin nerr++; $display("FAIL viol_dropped: got %0d requests busy=%b want 1/0", n_req - r0, ld_busy); end
   endtask

   task automatic test_timeout;
      int   hi;
      logic dropped;
      hi = 0; dropped = 1'b0;
      cart_rd = 1'b1; cart_addr = 20'h00ABC;
      for (int i = 0; i < 200 && !dropped; i++) begin
         @(negedge clk);
         if (mem_bus.mem_req) hi++;
         else if (hi > 0) dropped = 1'b1;
      end
      nvec++; if (hi !== 64) begin nerr++; $display("FAIL to_len: got %0d req cycles want 64", hi); end
      nvec++; if ({err_to, cart_valid, cart_data} !== {2'b11, 8'hFF}) begin nerr++; $display("FAIL to_result: got err=%b valid=%b data=%h want 1/1/ff", err_to, cart_valid, cart_data); end
      @(negedge clk);
      nvec++; if ({err_to, cart_valid, mem_bus.mem_req} !== 3'b100) begin nerr++; $display("FAIL to_after: got err,valid,req=%b want 100", {err_to, cart_valid, mem_bus.mem_req}); end
      cart_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_transfer;
      ld_wr = 1'b1; ld_addr = 25'h0000400; ld_data = 8'h44;
      @(negedge clk);
      ld_wr = 1'b0;
      nvec++; if (mem_bus.mem_req !== 1'b1) begin nerr++; $display("FAIL mid_req: got %b want 1", mem_bus.mem_req); end
      reset = 1'b1;
      @(negedge clk);
      nvec++; if ({mem_bus.mem_req, ld_busy, err_to} !== 3'b000) begin nerr++; $display("FAIL mid_reset: got req,busy,err=%b want 000", {mem_bus.mem_req, ld_busy, err_to}); end
      reset = 1'b0;
      cart_rd = 1'b1; cart_addr = 20'h00100;
      @(negedge clk);
      nvec++; if (mem_bus.mem_req !== 1'b1) begin nerr++; $display("FAIL mid_cache_cleared: got req %b want 1", mem_bus.mem_req); end
      serve(1, 8'h99);
      nvec++; if ({cart_valid, cart_data} !== {1'b1, 8'h99}) begin nerr++; $display("FAIL mid_read: got valid=%b data=%h want 1/99", cart_valid, cart_data); end
      cart_rd = 1'b0;
      @(negedge clk);
   endtask

`ifdef CART_PREFETCH_EN
   task automatic test_prefetch_wrap;
      int r0;
      repeat (70) @(negedge clk);
      cart_rd = 1'b1; cart_addr = 20'hFFFFF;
      @(negedge clk);
      nvec++; if (mem_bus.mem_addr !== 25'h00FFFFF) begin nerr++; $display("FAIL pf_first: got %h want 00fffff", mem_bus.mem_addr); end
      serve(1, 8'h11);
      nvec++; if (cart_data !== 8'h11) begin nerr++; $display("FAIL pf_first_data: got %h want 11", cart_data); end
      cart_rd = 1'b0;
      @(negedge clk);
      nvec++; if ({mem_bus.mem_req, mem_bus.mem_addr} !== {1'b1, 25'h0}) begin nerr++; $display("FAIL pf_target: got req=%b addr=%h want 1/0000000", mem_bus.mem_req, mem_bus.mem_addr); end
      serve(1, 8'h22);
      r0 = n_req;
      cart_rd = 1'b1; cart_addr = 20'h00000;
      @(negedge clk);
      nvec++; if ({cart_valid, cart_data, mem_bus.mem_req} !== {1'b1, 8'h22, 1'b0}) begin nerr++; $display("FAIL pf_hit: got valid=%b data=%h req=%b want 1/22/0", cart_valid, cart_data, mem_bus.mem_req); end
      repeat (2) @(negedge clk);
      nvec++; if (n_req - r0 !== 0) begin nerr++; $display("FAIL pf_no_req: got %0d requests want 0", n_req - r0); end
      cart_rd = 1'b0;
   endtask
`endif

   initial begin
      nvec = 0; nerr = 0; n_req = 0; req_q = 1'b0;
      reset = 1'b1; ld_wr = 1'b0; ld_addr = 25'h0; ld_data = 8'h00;
      cart_rd = 1'b0; cart_addr = 20'h00000;
      mem_bus.mem_ack = 1'b0; mem_bus.mem_dout = 8'h00;
      @(negedge clk);
      test_reset();
      test_loader_write();
      test_cart_miss_hit();
      test_write_and_read_same_cycle();
      test_write_invalidate();
      test_protocol_violation();
      test_timeout();
      test_reset_mid_transfer();
`ifdef CART_PREFETCH_EN
      test_prefetch_wrap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
